// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Entry layouts for the prefetch queue, the NOP used for fault markers, and word alignment.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        misalign;
    } fetch_entry_t;

    // Narrower entry used when misaligned-target markers cannot occur
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_word_t;

    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam logic [31:0] INST_BYTES = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: register-array FIFO with flush, natural pointer wrap and occupancy count.
// Flush wins over push/pop; a push while full is accepted only alongside a pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  entry_t                   din,
    output entry_t                   dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !flush && !empty;
    assign do_push = push && !flush && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + (AW + 1)'(1);
            else if (do_pop && !do_push)
                count <= count - (AW + 1)'(1);
        end
    end

    // Payload storage is never reset; occupancy alone decides what is visible
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// PC generator and prefetch queue feeding decode over valid/ready, with execute redirects.
// Define FETCH_MISALIGN_EN to turn misaligned redirect targets into a halting marker entry.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
)
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
`ifdef FETCH_MISALIGN_EN
    ,
    output logic        out_misalign
`endif
);

`ifdef FETCH_MISALIGN_EN
    typedef fetch_entry_t q_entry_t;
`else
    typedef fetch_word_t  q_entry_t;
`endif

    logic [31:0]          pc;
    logic                 full;
    logic                 empty;
    logic [$clog2(DEPTH):0] count;
    logic                 pop;
    logic                 push;
    logic                 fetch_en;
    q_entry_t             din;
    q_entry_t             head;

    assign imem_addr = align_word(pc);
    assign out_valid = (count != '0);
    assign pop       = !empty && out_ready && !redirect_valid;
    assign out_pc    = out_valid ? head.pc   : '0;
    assign out_inst  = out_valid ? head.inst : '0;

`ifdef FETCH_MISALIGN_EN
    logic        halted;
    logic        mark_pending;
    logic        mark_push;
    logic [31:0] mark_pc;

    assign fetch_en     = !redirect_valid && (!full || pop) && !halted;
    // The flush on redirect guarantees room for the marker in the following cycle
    assign mark_push    = !redirect_valid && mark_pending;
    assign push         = fetch_en || mark_push;
    assign out_misalign = out_valid && head.misalign;

    always_comb begin
        din = '{pc: imem_addr, inst: imem_inst, misalign: 1'b0};
        if (mark_push) din = '{pc: mark_pc, inst: NOP_INST, misalign: 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted       <= 1'b0;
            mark_pending <= 1'b0;
        end else if (redirect_valid) begin
            halted       <= |redirect_pc[1:0];
            mark_pending <= |redirect_pc[1:0];
        end else if (mark_push) begin
            mark_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (redirect_valid) mark_pc <= redirect_pc;
    end
`else
    assign fetch_en = !redirect_valid && (!full || pop);
    assign push     = fetch_en;

    always_comb begin
        din = '{pc: imem_addr, inst: imem_inst};
    end
`endif

    // PC: redirect overrides sequential advance; holds while the queue is full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= RESET_PC;
        else if (redirect_valid)
            pc <= align_word(redirect_pc);
        else if (fetch_en)
            pc <= pc + INST_BYTES;
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (q_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: expected fetch stream queued at stimulus, popped on handshake.
// Memory model returns word index (addr>>2) as the instruction.
`timescale 1ns/1ps
module tb_inst_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        mis;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        mis;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] gen_pc;
    bit          gen_on;
    int          total = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    assign imem_inst = {2'b00, imem_addr[31:2]};

    inst_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
`ifdef FETCH_MISALIGN_EN
        ,
        .out_misalign   (mis)
`endif
    );

`ifndef FETCH_MISALIGN_EN
    assign mis = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Expected sequence: consecutive words from the latest redirect/reset target
    task automatic refill();
        while (gen_on && expq.size() < 16) begin
            expq.push_back('{pc: gen_pc, inst: {2'b00, gen_pc[31:2]}, mis: 1'b0});
            gen_pc = gen_pc + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] target);
        expq.delete();
        gen_pc = target & ~32'h3;
        gen_on = 1'b1;
        refill();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        refill();
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        restart(target);
    endtask

    // Monitor: every accepted head must be the next expected entry
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !redirect_valid) begin
            if (expq.size() == 0) begin
                total++;
                $display("FAIL unexpected_entry: got pc %h expected no entry", out_pc);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("head_pc", out_pc, e.pc);
                chk("head_inst", out_inst, e.inst);
                chk("head_misalign", {31'b0, mis}, {31'b0, e.mis});
            end
        end
    end

    initial begin
        logic [31:0] tgt;
        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        restart(RESET_PC);

        #12;
        chk("reset_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_pc", out_pc, 32'd0);
        chk("reset_inst", out_inst, 32'd0);
        chk("reset_imem_addr", imem_addr, RESET_PC);
        chk("reset_misalign", {31'b0, mis}, 32'd0);

        // Reset release with decode always ready: one entry per cycle from the first edge
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        chk("first_valid", {31'b0, out_valid}, 32'd1);
        chk("first_pc", out_pc, RESET_PC);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("stream_valid", {31'b0, out_valid}, 32'd1);
        end

        // Asynchronous reset between edges mid-drain
        #2;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        restart(RESET_PC);
        #1;
        chk("async_reset_valid", {31'b0, out_valid}, 32'd0);
        chk("async_reset_imem_addr", imem_addr, RESET_PC);
        step();
        step();
        rst_n = 1'b1;

        // Decode stalled: queue fills to DEPTH and the PC holds
        for (int i = 0; i < 10; i++) step();
        chk("full_valid", {31'b0, out_valid}, 32'd1);
        chk("full_head_pc", out_pc, RESET_PC);
        chk("full_imem_addr", imem_addr, RESET_PC + 32'(4 * DEPTH));
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("drain_valid", {31'b0, out_valid}, 32'd1);
        end

        // Redirect while full with decode ready
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) step();
        out_ready = 1'b1;
        redirect_to(32'h100);
        step();
        redirect_valid = 1'b0;
        chk("redir_gap_valid", {31'b0, out_valid}, 32'd0);
        step();
        chk("redir_valid", {31'b0, out_valid}, 32'd1);
        chk("redir_head_pc", out_pc, 32'h100);
        for (int i = 0; i < 5; i++) step();

        // Back-to-back redirects: the later target wins
        redirect_to(32'h200);
        step();
        redirect_to(32'h300);
        step();
        redirect_valid = 1'b0;
        chk("b2b_gap_valid", {31'b0, out_valid}, 32'd0);
        step();
        chk("b2b_head_pc", out_pc, 32'h300);
        for (int i = 0; i < 5; i++) step();

        // Misaligned redirect target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
`ifdef FETCH_MISALIGN_EN
        expq.delete();
        gen_on = 1'b0;
        expq.push_back('{pc: 32'h102, inst: 32'h13, mis: 1'b1});
`else
        restart(32'h102);
`endif
        step();
        redirect_valid = 1'b0;
        chk("mis_gap_valid", {31'b0, out_valid}, 32'd0);
        step();
        chk("mis_valid", {31'b0, out_valid}, 32'd1);
`ifdef FETCH_MISALIGN_EN
        chk("mis_head_pc", out_pc, 32'h102);
        chk("mis_head_inst", out_inst, 32'h13);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("halted_idle", {31'b0, out_valid}, 32'd0);
        end
        redirect_to(32'h40);
        step();
        redirect_valid = 1'b0;
        step();
        chk("resume_head_pc", out_pc, 32'h40);
`else
        chk("mis_head_pc", out_pc, 32'h100);
`endif
        for (int i = 0; i < 5; i++) step();

        // PC wrap past the top of the address space
        redirect_to(32'hFFFF_FFF8);
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // Randomized ready and redirect traffic
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                tgt = $urandom();
`ifdef FETCH_MISALIGN_EN
                tgt = tgt & ~32'h3;
`endif
                redirect_to(tgt);
            end else begin
                redirect_valid = 1'b0;
            end
            step();
        end
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        for (int i = 0; i < 8; i++) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
